// File: rtl/backing_mem.sv
// backing_mem: word-granular memory responder behind the instruction and data caches.
// One request in flight at a time; each completes a fixed LATENCY cycles after acceptance.
module backing_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_ready,
    input  logic [31:0] i_mem_addr,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_valid
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit FAST = (LATENCY == 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    state_t        r_state;
    op_t           r_op;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_ready;
    logic          r_valid;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_req_idx;
    logic          w_one_op;
    logic          w_accept;
    logic          w_done;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_wr_data;
    logic [31:0]   w_unused_addr;

    // Upper address bits alias onto the array; byte-offset bits are ignored.
    assign w_req_idx     = i_mem_addr[AW+1:2];
    assign w_unused_addr = i_mem_addr;

    assign w_one_op = i_mem_ren ^ i_mem_wen;
    assign w_accept = i_rst_n && (r_state == ST_IDLE) && w_one_op;
    assign w_done   = i_rst_n && (r_state == ST_BUSY) && (r_cnt == CNT_ONE);

    // With unit latency the request completes on its own acceptance edge.
    always_comb begin
        w_rd_fire = 1'b0;
        w_wr_fire = 1'b0;
        w_rd_idx  = r_idx;
        w_wr_idx  = r_idx;
        w_wr_data = r_wdata;
        if (FAST) begin
            w_rd_fire = w_accept && i_mem_ren;
            w_wr_fire = w_accept && i_mem_wen;
            w_rd_idx  = w_req_idx;
            w_wr_idx  = w_req_idx;
            w_wr_data = i_mem_wdata;
        end else begin
            w_rd_fire = w_done && (r_op == OP_RD);
            w_wr_fire = w_done && (r_op == OP_WR);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_RD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rdata <= r_mem[w_rd_idx];
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= w_req_idx;
                        r_wdata <= i_mem_wdata;
                        r_op    <= i_mem_wen ? OP_WR : OP_RD;
                        if (!FAST) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CNT_LOAD;
                            r_ready <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    assign o_mem_ready = r_ready && i_rst_n;
    assign o_mem_valid = r_valid;
    assign o_mem_rdata = r_rdata;

endmodule

// File: doc/backing_mem.md
# backing_mem

Word-granular backing-memory responder for the external memory interface driven by the instruction and data caches. It accepts one read or write request at a time through a ready/valid handshake, and holds a synchronous word array. Each request completes after a fixed, parameterised latency. It sits on the memory side of each cache and serves as the simulation and FPGA memory model behind the cache miss and write-through paths.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words; must be a power of two ≥ 2. `AW = $clog2(DEPTH_WORDS)`.
- `LATENCY`, default 4: cycles from request acceptance to completion; must be ≥ 1.
- `i_clk` input 1: the single clock.
- `i_rst_n` input 1: one clock; reset is synchronous and active-low.
- `o_mem_ready` output 1: responder can accept a request this cycle.
- `i_mem_addr` input 32: byte address; bits [1:0] ignored; word index = `i_mem_addr[AW+1:2]`; upper bits ignored (aliasing).
- `i_mem_ren` input 1: read request.
- `i_mem_wen` input 1: write request (full word, no mask).
- `i_mem_wdata` input 32: write data.
- `o_mem_rdata` output 32: read data, meaningful only while `o_mem_valid` = 1.
- `o_mem_valid` output 1: single-cycle read-completion strobe.

## Operation
- States: IDLE and BUSY.
- **IDLE**
  - `o_mem_ready` = 1.
  - A request is accepted when `o_mem_ready` = 1 and exactly one of `i_mem_ren` / `i_mem_wen` is 1 at a rising edge.
  - On acceptance, latch word index, wdata and op type, load the latency counter with `LATENCY-1`, and go to BUSY.
  - If `LATENCY` = 1, skip BUSY and complete the request at the next edge.
- **BUSY**
  - `o_mem_ready` = 0.
  - The counter decrements each cycle.
  - `i_mem_*` inputs are ignored; requests asserted here are dropped, not queued.
  - When the counter reaches 0, the op completes and the state returns to IDLE.
- **Completion of a read:** `o_mem_rdata` = array[latched index], and `o_mem_valid` = 1 for exactly one cycle.
- **Completion of a write:** array[latched index] ← latched wdata. `o_mem_valid` stays 0; the return of `o_mem_ready` signals write completion.
- **Both `i_mem_ren` and `i_mem_wen` high** (illegal): the request is not accepted, no state change, and `o_mem_ready` stays 1.
- **Counter:** width `$clog2(LATENCY+1)`; never wraps, because it is reloaded only on acceptance.
- **Array:** not cleared by reset. Initial contents are X, or loaded by the testbench via hierarchical `$readmemh`.

## Timing
- Request accepted at the edge ending cycle t.
- **Read:** `o_mem_valid` = 1 and `o_mem_rdata` valid during cycle t+LATENCY only.
- **Write:** the array update takes effect at the edge ending cycle t+LATENCY-1. A read accepted in cycle t+LATENCY returns the new data.
- `o_mem_ready` = 0 during cycles t+1 … t+LATENCY-1, and 1 again in cycle t+LATENCY, i.e. in the same cycle as `o_mem_valid`. A back-to-back request accepted in t+LATENCY therefore completes in t+2·LATENCY.
- **LATENCY = 1:** `o_mem_ready` never drops, and one request per cycle is sustained.
- `o_mem_rdata` holds its last value while `o_mem_valid` = 0.
- **Reset values** (while `i_rst_n` = 0 at an edge):
  - state = IDLE, counter = 0;
  - `o_mem_ready` = 0 during reset cycles and 1 from the first cycle after deassertion;
  - `o_mem_valid` = 0;
  - `o_mem_rdata` = 32'h0.
- **Reset mid-operation:** the pending op is discarded, no `o_mem_valid` pulse is produced, and a pending write that has not yet committed is not written.

## Test plan
- **Read latency.** Preload word 5 = 32'hDEADBEEF, LATENCY = 4. Read addr 32'h14 accepted in cycle 0 → `o_mem_ready` = 0 in cycles 1–3; `o_mem_valid` = 1 with rdata 32'hDEADBEEF in cycle 4 only; `o_mem_ready` = 1 in cycle 4.
- **Write then read.** Write 32'h12345678 to addr 32'h100 in cycle 0; read 32'h100 accepted in cycle 4 → cycle 8: `o_mem_valid` = 1, rdata 32'h12345678. No `o_mem_valid` pulse in cycles 1–7.
- **Busy and illegal requests dropped.** Assert read of 32'h200 while BUSY, and ren & wen together while IDLE → neither is accepted, no extra `o_mem_valid`, and array word 32'h200>>2 is unchanged.
- **Aliasing.** DEPTH_WORDS = 4096. Write 32'hA5A5A5A5 to 32'h0000_4008 → read of 32'h0000_0008 (and of 32'h0000_000B) returns 32'hA5A5A5A5.
- **Reset mid-write.** Write 32'hFFFFFFFF to addr 0 (previously 32'h0) accepted in cycle 0; `i_rst_n` = 0 in cycle 2 → outputs reach their reset values, `o_mem_ready` = 1 in the cycle after deassertion, and a later read of addr 0 returns 32'h0.
- **LATENCY = 1.** Reads of addrs 0, 4, 8 in consecutive cycles 0–2 → `o_mem_valid` = 1 in cycles 1–3 with the matching data, and `o_mem_ready` stays 1 throughout.
